ps2_scancode_receiver: RTL and testbench

Deserialises PS/2 keyboard frames from the `ps2_clk`/`ps2_data` pins into 8-bit make codes for the game logic. The key-press path consumes this output as `tasta` and `done`. The block validates each frame (start, odd parity, stop) and strips break (F0) sequences, so only key presses reach the game. An `E0` prefix is reported as a flag on the following code. It holds `done` high long enough for a consumer that samples only during the VGA active zone.

---
 rtl/ps2_scancode_receiver.sv | 188 ++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the pins, validates 11-bit frames,
// strips break (F0) sequences and publishes make codes with a held `done` flag.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int DONE_HOLD      = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tasta,
  output logic       extended,
  output logic       done,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(DONE_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_q, fall;
  logic [FW-1:0] filt_cnt;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          code_valid;
  logic [7:0]    code;

  logic          brk_pending, ext_pending;
  logic [HW-1:0] hold_cnt;
  logic          q_valid, q_ext;
  logic [7:0]    q_code;
  logic          pub_req;

  // Input path: 2-flop synchronisers, stability filter on the clock, registered fall strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the pin pipeline resets to the idle-high bus level so reset never fakes a fall.
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt   <= '0;
      fall       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
      // synchroniser really is two stages regardless of statement order.
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      clk_filt_q <= clk_filt;
      fall       <= clk_filt_q & ~clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM with inter-edge timeout; a fall always wins over an expiring timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_bit  <= 1'b0;
      tmo_cnt     <= '0;
      frame_error <= 1'b0;
      code_valid  <= 1'b0;
      code        <= '0;
    end else begin
      frame_error <= 1'b0;
      code_valid  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            parity_bit <= dat_s2;
            state      <= S_STOP;
          end
          default: begin
            if (dat_s2 && (^shift ^ parity_bit)) begin
              code       <= shift;
              code_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= S_IDLE;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
          state       <= S_IDLE;
          frame_error <= 1'b1;
          tmo_cnt     <= '0;
          bit_cnt     <= '0;
          shift       <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  assign pub_req = code_valid && (code != 8'hF0) && (code != 8'hE0) && !brk_pending;

  // Decode and publish. A publish during `done` opens a one-cycle gap; the code waits in q_*.
  always_ff @(posedge clock) begin
    if (reset) begin
      tasta       <= 8'h00;
      extended    <= 1'b0;
      done        <= 1'b0;
      hold_cnt    <= '0;
      brk_pending <= 1'b0;
      ext_pending <= 1'b0;
      q_valid     <= 1'b0;
      q_code      <= '0;
      q_ext       <= 1'b0;
    end else begin
      if (code_valid) begin
        if (code == 8'hF0) begin
          brk_pending <= 1'b1;
        end else if (code == 8'hE0) begin
          ext_pending <= 1'b1;
        end else begin
          brk_pending <= 1'b0;
          ext_pending <= 1'b0;
        end
      end

      if (q_valid && !done) begin
        tasta    <= q_code;
        extended <= q_ext;
        done     <= 1'b1;
        hold_cnt <= HW'(DONE_HOLD);
        q_valid  <= pub_req;
        q_code   <= code;
        q_ext    <= ext_pending;
      end else if (pub_req && done) begin
        done    <= 1'b0;
        q_valid <= 1'b1;
        q_code  <= code;
        q_ext   <= ext_pending;
      end else if (q_valid) begin
        done <= 1'b0;
      end else if (pub_req) begin
        tasta    <= code;
        extended <= ext_pending;
        done     <= 1'b1;
        hold_cnt <= HW'(DONE_HOLD);
      end else if (done) begin
        if (hold_cnt == HW'(1)) done <= 1'b0;
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frame table plus hand-written sequences for
// timeout, glitch rejection, publish-during-done gap and reset mid-frame.
module tb_ps2_scancode_receiver;

  localparam int FILT     = 4;
  localparam int TMO      = 200;
  localparam int HOLD     = 20;
  localparam int HOLD_L   = 500;
  localparam int HALF     = 20;
  // Raw pin edge -> fall strobe takes FILT+3 edges; FSM +1; decode +1.
  localparam int ERR_LAT  = FILT + 4;
  localparam int PUB_LAT  = FILT + 5;
  localparam int GAP_LAT  = FILT + 6;
  localparam int TMO_LAT  = FILT + TMO + 5;

  logic       clock, reset, ps2_clk, ps2_data;
  logic [7:0] tasta, tasta_l;
  logic       extended, done, frame_error;
  logic       extended_l, done_l, frame_error_l;

  ps2_scancode_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .DONE_HOLD(HOLD)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tasta(tasta), .extended(extended), .done(done), .frame_error(frame_error)
  );

  // Long-hold instance so a second frame can land while done is still high.
  ps2_scancode_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .DONE_HOLD(HOLD_L)) dut_long (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tasta(tasta_l), .extended(extended_l), .done(done_l), .frame_error(frame_error_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int done_rises = 0, last_rise = 0, last_width = 0;
  int err_pulses = 0, last_err = 0, err_wide = 0;
  int rises_l = 0, rise_l = 0, fall_l = 0, width_l = 0, low_len_l = 0;
  logic done_q = 1'b0, err_q = 1'b0, done_lq = 1'b0;
  int last_fall_cyc = 0;

  always @(negedge clock) begin
    if (done && !done_q) begin
      done_rises++;
      last_rise = cyc;
    end
    if (!done && done_q) last_width = cyc - last_rise;
    if (frame_error) begin
      if (err_q) err_wide++;
      else begin
        err_pulses++;
        last_err = cyc;
      end
    end
    if (done_l && !done_lq) begin
      rises_l++;
      low_len_l = cyc - fall_l;
      rise_l = cyc;
    end
    if (!done_l && done_lq) begin
      fall_l = cyc;
      width_l = cyc - rise_l;
    end
    done_q  = done;
    err_q   = frame_error;
    done_lq = done_l;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bits({~bad_stop, par, code, 1'b0}, 11);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    int         exp_pub;
    logic [7:0] exp_tasta;
    logic       exp_ext;
    int         exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int r0, e0, rl0, stop2;

    vecs[0]  = '{8'h29, 1'b0, 1'b0, 1, 8'h29, 1'b0, 0};
    vecs[1]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 0};
    vecs[3]  = '{8'h1C, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 0};
    vecs[5]  = '{8'h6B, 1'b0, 1'b0, 1, 8'h6B, 1'b1, 0};
    vecs[6]  = '{8'h23, 1'b1, 1'b0, 0, 8'h6B, 1'b1, 1};
    vecs[7]  = '{8'h23, 1'b0, 1'b1, 0, 8'h6B, 1'b1, 1};
    vecs[8]  = '{8'h23, 1'b0, 1'b0, 1, 8'h23, 1'b0, 0};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h23, 1'b0, 0};
    vecs[10] = '{8'h75, 1'b1, 1'b0, 0, 8'h23, 1'b0, 1};
    vecs[11] = '{8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b1, 0};
    vecs[12] = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 0};

    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(20);
    check("reset_tasta", tasta, 8'h00);
    check("reset_extended", extended, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_frame_error", err_pulses, 0);

    for (int i = 0; i < 13; i++) begin
      r0 = done_rises;
      e0 = err_pulses;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      wait_cyc(40);
      check($sformatf("v%0d_publishes", i), done_rises - r0, vecs[i].exp_pub);
      check($sformatf("v%0d_tasta", i), tasta, vecs[i].exp_tasta);
      check($sformatf("v%0d_extended", i), extended, vecs[i].exp_ext);
      check($sformatf("v%0d_errors", i), err_pulses - e0, vecs[i].exp_err);
      if (vecs[i].exp_pub == 1) begin
        check($sformatf("v%0d_done_latency", i), last_rise - last_fall_cyc, PUB_LAT);
        check($sformatf("v%0d_done_width", i), last_width, HOLD);
      end
      if (vecs[i].exp_err == 1)
        check($sformatf("v%0d_err_latency", i), last_err - last_fall_cyc, ERR_LAT);
    end

    // Abort after start + 4 data bits, then idle past the timeout.
    r0 = done_rises;
    e0 = err_pulses;
    send_bits({3'b111, 8'h76, 1'b0}, 5);
    wait_cyc(250);
    check("tmo_errors", err_pulses - e0, 1);
    check("tmo_latency", last_err - last_fall_cyc, TMO_LAT);
    check("tmo_no_publish", done_rises - r0, 0);
    send_frame(8'h76, 1'b0, 1'b0);
    wait_cyc(40);
    check("after_tmo_tasta", tasta, 8'h76);
    check("after_tmo_latency", last_rise - last_fall_cyc, PUB_LAT);

    // Short clock glitch with data low: if accepted it would start a frame and time out.
    r0 = done_rises;
    e0 = err_pulses;
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(FILT - 1);
    ps2_clk = 1'b1;
    wait_cyc(300);
    ps2_data = 1'b1;
    check("glitch_no_error", err_pulses - e0, 0);
    check("glitch_no_publish", done_rises - r0, 0);

    // Second code lands while the long instance still holds done high.
    wait_cyc(600);
    rl0 = rises_l;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    stop2 = last_fall_cyc;
    wait_cyc(40);
    check("gap_rises", rises_l - rl0, 2);
    check("gap_low_len", low_len_l, 1);
    check("gap_rise_latency", rise_l - stop2, GAP_LAT);
    check("gap_tasta", tasta_l, 8'h23);
    check("gap_done_high", done_l, 1'b1);
    check("gap_main_tasta", tasta, 8'h23);
    wait_cyc(520);
    check("gap_fresh_hold", width_l, HOLD_L);

    // Reset after 5 data bits, then a clean frame.
    send_bits({3'b111, 8'h16, 1'b0}, 6);
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(3);
    check("rst_mid_tasta", tasta, 8'h00);
    check("rst_mid_extended", extended, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_frame_error", frame_error, 1'b0);
    check("rst_mid_tasta_long", tasta_l, 8'h00);
    reset = 1'b0;
    wait_cyc(20);
    r0 = done_rises;
    e0 = err_pulses;
    send_frame(8'h16, 1'b0, 1'b0);
    wait_cyc(40);
    check("post_rst_tasta", tasta, 8'h16);
    check("post_rst_extended", extended, 1'b0);
    check("post_rst_publishes", done_rises - r0, 1);
    check("post_rst_errors", err_pulses - e0, 0);
    check("post_rst_latency", last_rise - last_fall_cyc, PUB_LAT);

    check("err_pulse_one_cycle", err_wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
